// File: rtl/led_matrix_scan_ctrl.sv
// Double-buffered LED matrix line scanner; new frames wait in a shadow buffer and swap in only at frame boundaries.
// All display outputs are registered; frame_ready is low while the shadow holds a frame that has not been swapped in.
module led_matrix_scan_ctrl #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    tick,
   input  logic [ROWS*COLS-1:0]    frame_in,
   input  logic                    frame_valid,
   output logic                    frame_ready,
   output logic [COLS-1:0]         data_out,
   output logic [ROWS-1:0]         sel_n,
   output logic [$clog2(ROWS)-1:0] line_idx,
   output logic                    frame_done
);

   localparam int IW = $clog2(ROWS);
   localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int FW = ROWS * COLS;

   localparam logic [IW-1:0]   LAST_LINE  = IW'(ROWS - 1);
   localparam logic [CW-1:0]   BLANK_LOAD = CW'(BLANK_CYCLES - 1);
   localparam logic [ROWS-1:0] TOP_SEL    = {1'b1, {(ROWS-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHOW  = 2'd1,
      S_BLANK = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [FW-1:0]   shadow;
   logic [FW-1:0]   active;
   logic            shadow_full;
   logic [CW-1:0]   blank_cnt;
   logic [CW-1:0]   blank_cnt_nxt;
   logic [COLS-1:0] data_nxt;
   logic [ROWS-1:0] sel_nxt;
   logic [IW-1:0]   idx_nxt;
   logic            done_nxt;
   logic            swap;
   logic            accept;

   // Line 0 is the most significant slice of the frame.
   function automatic logic [COLS-1:0] line_of(input logic [FW-1:0] f, input logic [IW-1:0] k);
      logic [FW-1:0] aligned;
      aligned = f << (int'(k) * COLS);
      return aligned[FW-1 -: COLS];
   endfunction

   // Line 0 drives the top select bit, matching the frame slice order.
   function automatic logic [ROWS-1:0] sel_of(input logic [IW-1:0] k);
      return ~(TOP_SEL >> k);
   endfunction

   assign frame_ready = !shadow_full;
   assign accept      = frame_valid && !shadow_full;

   always_comb begin
      state_nxt     = state;
      data_nxt      = data_out;
      sel_nxt       = sel_n;
      idx_nxt       = line_idx;
      done_nxt      = 1'b0;
      blank_cnt_nxt = blank_cnt;
      swap          = 1'b0;

      case (state)
         S_IDLE: begin
            data_nxt = '0;
            sel_nxt  = '1;
            if (enable && shadow_full) begin
               swap      = 1'b1;
               idx_nxt   = '0;
               data_nxt  = line_of(shadow, '0);
               sel_nxt   = sel_of('0);
               state_nxt = S_SHOW;
            end
         end

         S_SHOW: begin
            if (tick) begin
               data_nxt      = '0;
               sel_nxt       = '1;
               blank_cnt_nxt = BLANK_LOAD;
               state_nxt     = S_BLANK;
            end
         end

         S_BLANK: begin
            data_nxt = '0;
            sel_nxt  = '1;
            if (blank_cnt != '0) begin
               blank_cnt_nxt = blank_cnt - CW'(1);
            end else if (line_idx != LAST_LINE) begin
               idx_nxt   = line_idx + IW'(1);
               data_nxt  = line_of(active, line_idx + IW'(1));
               sel_nxt   = sel_of(line_idx + IW'(1));
               state_nxt = S_SHOW;
            end else begin
               // End of frame: the only scan point where enable and a pending frame matter.
               done_nxt = 1'b1;
               idx_nxt  = '0;
               if (!enable) begin
                  state_nxt = S_IDLE;
               end else if (shadow_full) begin
                  swap      = 1'b1;
                  data_nxt  = line_of(shadow, '0);
                  sel_nxt   = sel_of('0);
                  state_nxt = S_SHOW;
               end else begin
                  data_nxt  = line_of(active, '0);
                  sel_nxt   = sel_of('0);
                  state_nxt = S_SHOW;
               end
            end
         end

         default: begin
            data_nxt      = '0;
            sel_nxt       = '1;
            blank_cnt_nxt = '0;
            state_nxt     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         shadow      <= '0;
         active      <= '0;
         shadow_full <= 1'b0;
         blank_cnt   <= '0;
         data_out    <= '0;
         sel_n       <= '1;
         line_idx    <= '0;
         frame_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         blank_cnt  <= blank_cnt_nxt;
         data_out   <= data_nxt;
         sel_n      <= sel_nxt;
         line_idx   <= idx_nxt;
         frame_done <= done_nxt;
         // A swap needs shadow_full, so it can never coincide with an accept.
         if (swap) begin
            active      <= shadow;
            shadow_full <= 1'b0;
         end else if (accept) begin
            shadow      <= frame_in;
            shadow_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl (8x8, two blank clocks): frame-level model checked every cycle plus literal checks.
module tb_led_matrix_scan_ctrl;

   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int BLANK = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        tick;
   logic [63:0] frame_in;
   logic        frame_valid;
   logic        frame_ready;
   logic [7:0]  data_out;
   logic [7:0]  sel_n;
   logic [2:0]  line_idx;
   logic        frame_done;

   int tests = 0;
   int fails = 0;
   int done_seen = 0;

   led_matrix_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .BLANK_CYCLES(BLANK)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .tick        (tick),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .data_out    (data_out),
      .sel_n       (sel_n),
      .line_idx    (line_idx),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   // Model: scanning or not, which line, and how many dark clocks remain (0 = lit).
   bit          m_scan;
   int          m_line;
   int          m_dark;
   logic [63:0] m_active;
   logic [63:0] m_shadow;
   bit          m_full;
   bit          m_done;

   function automatic logic [7:0] slice(input logic [63:0] f, input int k);
      return 8'(f >> ((ROWS - 1 - k) * COLS));
   endfunction

   function automatic logic [7:0] exp_data();
      return (m_scan && m_dark == 0) ? slice(m_active, m_line) : 8'h00;
   endfunction

   function automatic logic [7:0] exp_sel();
      return (m_scan && m_dark == 0) ? (8'hFF ^ (8'h80 >> m_line)) : 8'hFF;
   endfunction

   task automatic model_reset();
      m_scan = 0; m_line = 0; m_dark = 0; m_active = '0; m_shadow = '0; m_full = 0; m_done = 0;
   endtask

   task automatic model_step();
      bit          acc;
      logic [63:0] fin;
      acc    = frame_valid && !m_full;
      fin    = frame_in;
      m_done = 0;
      if (!m_scan) begin
         if (enable && m_full) begin
            m_active = m_shadow; m_full = 0; m_line = 0; m_dark = 0; m_scan = 1;
         end
      end else if (m_dark == 0) begin
         if (tick) m_dark = BLANK;
      end else begin
         m_dark--;
         if (m_dark == 0) begin
            if (m_line < ROWS - 1) begin
               m_line++;
            end else begin
               m_done = 1;
               m_line = 0;
               if (!enable) m_scan = 0;
               else if (m_full) begin
                  m_active = m_shadow; m_full = 0;
               end
            end
         end
      end
      if (acc) begin
         m_shadow = fin; m_full = 1;
      end
   endtask

   always @(posedge clk) begin
      if (!rst) model_reset();
      else model_step();
   end

   always @(negedge rst) model_reset();

   always @(negedge clk) begin
      tests++;
      if (frame_ready !== !m_full || data_out !== exp_data() || sel_n !== exp_sel() ||
          line_idx !== 3'(m_line) || frame_done !== m_done) begin
         fails++;
         $display("FAIL cycle_model t=%0t ready=%b/%b data=%h/%h sel=%b/%b idx=%0d/%0d done=%b/%b (got/want)",
                  $time, frame_ready, !m_full, data_out, exp_data(), sel_n, exp_sel(),
                  line_idx, m_line, frame_done, m_done);
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // One tick pulse, then wait out the blanking; ends on the negedge where the next line is lit.
   task automatic tick_line();
      tick = 1'b1;
      @(negedge clk);
      if (frame_done) done_seen++;
      tick = 1'b0;
      repeat (BLANK) begin
         @(negedge clk);
         if (frame_done) done_seen++;
      end
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; tick = 1'b0; frame_valid = 1'b0; frame_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_sel", sel_n, 64'hFF);
      chk("rst_data", data_out, 64'h0);
      chk("rst_ready", frame_ready, 64'h1);
      chk("rst_idx", line_idx, 64'h0);
      chk("rst_done", frame_done, 64'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_dark", sel_n, 64'hFF);

      // First frame: accept, then swap and show line 0
      frame_in = 64'hAA55AA55AA55AA55; frame_valid = 1'b1; enable = 1'b1;
      @(negedge clk);
      chk("accept_ready_low", frame_ready, 64'h0);
      chk("accept_still_dark", data_out, 64'h0);
      frame_valid = 1'b0; frame_in = '0;
      @(negedge clk);
      chk("line0_sel", sel_n, 64'h7F);
      chk("line0_data", data_out, 64'hAA);
      chk("swap_ready_high", frame_ready, 64'h1);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("blank1_sel", sel_n, 64'hFF);
      chk("blank1_data", data_out, 64'h0);
      @(negedge clk);
      chk("blank2_sel", sel_n, 64'hFF);
      @(negedge clk);
      chk("line1_sel", sel_n, 64'hBF);
      chk("line1_data", data_out, 64'h55);

      // Full frame with no new data repeats
      done_seen = 0;
      repeat (7) tick_line();
      chk("repeat_done_count", done_seen, 64'd1);
      chk("repeat_done_pulse", frame_done, 64'h1);
      chk("repeat_line0_data", data_out, 64'hAA);
      chk("repeat_line0_sel", sel_n, 64'h7F);
      @(negedge clk);
      chk("done_one_clock", frame_done, 64'h0);

      // New frame offered mid-scan waits for the boundary; second offer is ignored
      repeat (3) tick_line();
      chk("at_line3", line_idx, 64'd3);
      frame_in = 64'hFF00000000000000; frame_valid = 1'b1;
      @(negedge clk);
      chk("mid_accept_ready", frame_ready, 64'h0);
      frame_in = 64'h0123456789ABCDEF;
      tick_line(); chk("old_line4", data_out, 64'hAA);
      tick_line(); chk("old_line5", data_out, 64'h55);
      tick_line(); chk("old_line6", data_out, 64'hAA);
      frame_valid = 1'b0; frame_in = '0;
      tick_line(); chk("old_line7", data_out, 64'h55);
      chk("still_full", frame_ready, 64'h0);
      tick_line();
      chk("new_line0_data", data_out, 64'hFF);
      chk("new_line0_sel", sel_n, 64'h7F);
      chk("new_ready_back", frame_ready, 64'h1);
      tick_line();
      chk("new_line1_data", data_out, 64'h00);
      chk("new_line1_sel", sel_n, 64'hBF);

      // Dropping enable mid-frame finishes the frame then idles
      tick_line();
      enable = 1'b0; done_seen = 0;
      repeat (5) tick_line();
      chk("noen_line7_idx", line_idx, 64'd7);
      chk("noen_line7_sel", sel_n, 64'hFE);
      tick_line();
      chk("noen_done_count", done_seen, 64'd1);
      chk("noen_done", frame_done, 64'h1);
      chk("noen_dark_sel", sel_n, 64'hFF);
      chk("noen_dark_data", data_out, 64'h0);
      chk("noen_idx", line_idx, 64'd0);
      tick = 1'b1;
      repeat (4) @(negedge clk);
      tick = 1'b0;
      chk("idle_stays_dark", sel_n, 64'hFF);

      // Tick held through blanking is ignored there
      frame_in = 64'hAA55AA55AA55AA55; frame_valid = 1'b1; enable = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0; frame_in = '0;
      @(negedge clk);
      chk("restart_line0", data_out, 64'hAA);
      tick = 1'b1;
      repeat (BLANK + 1) @(negedge clk);
      tick = 1'b0;
      chk("held_tick_line1_sel", sel_n, 64'hBF);
      chk("held_tick_line1_data", data_out, 64'h55);

      // Async reset during line 5 with a frame pending
      repeat (4) tick_line();
      chk("at_line5", line_idx, 64'd5);
      frame_in = 64'h0F0F0F0F0F0F0F0F; frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0; frame_in = '0;
      chk("pending_ready", frame_ready, 64'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async_sel", sel_n, 64'hFF);
      chk("async_data", data_out, 64'h0);
      chk("async_ready", frame_ready, 64'h1);
      chk("async_idx", line_idx, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_ready", frame_ready, 64'h1);
      chk("post_rst_dark", sel_n, 64'hFF);
      chk("post_rst_data", data_out, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/led_matrix_scan_ctrl.md
LED_MATRIX_SCAN_CTRL -- requirements
Module: led_matrix_scan_ctrl

Interface
REQ-001 Parameter ROWS, default 8: number of multiplexed lines, ROWS >= 2.
REQ-002 Parameter COLS, default 8: pixels per line, COLS >= 1.
REQ-003 Parameter BLANK_CYCLES, default 2: dark clocks between lines, BLANK_CYCLES >= 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  1  scan permission, sampled only at frame boundaries and in IDLE.
REQ-007 tick  input  1  line-dwell pulse; ends the current line's display time.
REQ-008 frame_in  input  ROWS*COLS  frame; line k uses bits [(ROWS-k)*COLS-1 -: COLS], so line 0 is the MSB slice.
REQ-009 frame_valid  input  1  frame_in offered this cycle.
REQ-010 frame_ready  output  1  shadow buffer empty; frame_valid & frame_ready accepts the frame.
REQ-011 data_out  output  COLS  pixel data of the lit line, 1 = on.
REQ-012 sel_n  output  ROWS  line select, one-hot active-low; all ones = dark.
REQ-013 line_idx  output  clog2(ROWS)  index of the current or last lit line.
REQ-014 frame_done  output  1  one-clock pulse after the last line's blanking completes.

Function
REQ-015 Two ROWS*COLS buffers SHALL exist: shadow (written by the handshake) and active (scanned); shadow_full flag.
REQ-016 frame_ready SHALL equal !shadow_full combinationally; an accept SHALL set shadow_full at the same edge.
REQ-017 frame_valid while frame_ready=0 SHALL be ignored; the shadow is never overwritten.
REQ-018 A swap SHALL copy shadow to active and clear shadow_full in one edge; frame_ready SHALL rise on the following cycle.
REQ-019 FSM states: IDLE, SHOW, BLANK; data_out, sel_n, line_idx, frame_done SHALL be registered.
REQ-020 IDLE: outputs dark (data_out=0, sel_n=all ones). If enable=1 and shadow_full=1: swap, line_idx<=0, drive line 0 of the shadow, and go to SHOW at that edge. Otherwise stay in IDLE.
REQ-021 SHOW: hold data_out=active line line_idx and sel_n bit line_idx=0 until tick=1. On tick, go to BLANK with outputs dark and load the blank counter with BLANK_CYCLES-1.
REQ-022 BLANK: outputs stay dark for exactly BLANK_CYCLES clocks; tick is ignored; on the last blank clock:
  - if line_idx < ROWS-1: line_idx+1, drive that line, go to SHOW.
  - if line_idx = ROWS-1: pulse frame_done and set line_idx<=0; then
    - enable=0: go to IDLE;
    - enable=1 and shadow_full: swap and show line 0 of the new frame;
    - else: show line 0 of the same active frame (repeat).
REQ-023 Frame swaps SHALL occur only in IDLE or at the end-of-frame BLANK exit; a frame is never torn mid-scan.
REQ-024 Deasserting enable mid-frame SHALL NOT stop the scan before the frame ends.
REQ-025 An accept in the same cycle as a swap is impossible (frame_ready=0 then); an accept during any other cycle of any state SHALL be honoured.
REQ-026 At most one sel_n bit SHALL be low at any time; sel_n SHALL be all ones whenever data_out=0 is forced.
REQ-027 Illegal state encodings SHALL return to IDLE with outputs dark on the next edge.

Reset
REQ-028 While rst=0: state IDLE, active=0, shadow=0, shadow_full=0, frame_ready=1, data_out=0, sel_n=all ones, line_idx=0, frame_done=0, blank counter=0.
REQ-029 Reset asserted mid-scan or mid-handshake SHALL darken outputs immediately (asynchronously) and discard any pending shadow frame.

Verification (ROWS=COLS=8, BLANK_CYCLES=2)
REQ-030 Load frame 0xAA55AA55AA55AA55 with enable=1 -> next edge: sel_n=8'b01111111, data_out=0xAA; tick -> 2 dark clocks, then sel_n=8'b10111111, data_out=0x55.
REQ-031 Run 8 ticks with no new frame -> exactly one frame_done pulse after line 7's blanking, then line 0 shows 0xAA again (repeat).
REQ-032 Offer frame 0xFF00...00 during line 3 -> accepted, frame_ready=0; lines 4-7 still show the old data; the swap occurs at the frame boundary, line 0 shows 0xFF, and frame_ready returns to 1.
REQ-033 Hold frame_valid while frame_ready=0 with 0x0123... -> ignored; the shadow keeps the first offered frame.
REQ-034 Drop enable at line 2 -> lines 2-7 complete, frame_done pulses, state IDLE, outputs dark.
REQ-035 Assert rst during SHOW of line 5 -> sel_n=0xFF and data_out=0 without waiting for a clock edge, and frame_ready=1 after release.
